// File: rtl/npu_cmd_sequencer.sv
// rtl/npu_cmd_sequencer.sv - NPU command sequencer: local memory access strobes and compute/move start FSM
module npu_cmd_sequencer #(
    parameter int DWidth      = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int LADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] NPU_IMEM_START = ADDR_WIDTH'(32'h1000_0000),
    parameter logic [ADDR_WIDTH-1:0] NPU_WMEM_START = ADDR_WIDTH'(32'h1001_0000),
    parameter logic [ADDR_WIDTH-1:0] NPU_BMEM_START = ADDR_WIDTH'(32'h1002_0000),
    parameter logic [ADDR_WIDTH-1:0] NPU_OMEM_START = ADDR_WIDTH'(32'h1003_0000)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cen_i,
    input  logic [3:0]             op_type_i,
    input  logic [ADDR_WIDTH-1:0]  addr_i,
    input  logic [DWidth-1:0]      wdata_i,
    input  logic                   core_done_i,
    input  logic                   err_clr_i,
    output logic [2:0]             mem_we_o,
    output logic [LADDR_WIDTH-1:0] mem_addr_o,
    output logic [DWidth-1:0]      mem_wdata_o,
    output logic                   omem_re_o,
    output logic                   os_start_o,
    output logic                   mv_start_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [15:0]            wr_cnt_o
);

    localparam logic [3:0] OP_IMEM_WR = 4'b1000;
    localparam logic [3:0] OP_WMEM_WR = 4'b1001;
    localparam logic [3:0] OP_BMEM_WR = 4'b1010;
    localparam logic [3:0] OP_OMEM_RD = 4'b1011;
    localparam logic [3:0] OP_OS      = 4'b1111;
    localparam logic [3:0] OP_MV      = 4'b0001;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OS_START = 3'd1,
        OS_RUN   = 3'd2,
        MV_START = 3'd3,
        MV_RUN   = 3'd4,
        DONE     = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             mem_we_q, mem_we_d;
    logic [LADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DWidth-1:0]      mem_wdata_q, mem_wdata_d;
    logic                   omem_re_q, omem_re_d;
    logic                   err_q, err_d;
    logic [15:0]            wr_cnt_q, wr_cnt_d;

    logic                   cmd_valid;
    logic                   is_wr;
    logic                   is_rd;
    logic                   busy;
    logic                   running;
    logic                   take;
    logic                   new_err;
    logic [2:0]             we_sel;
    logic [ADDR_WIDTH-1:0]  region_base;

    // Command decode: which codes are recognised and which region they address
    always_comb begin
        cmd_valid   = 1'b0;
        is_wr       = 1'b0;
        is_rd       = 1'b0;
        we_sel      = 3'b000;
        region_base = NPU_IMEM_START;
        if (cen_i) begin
            unique case (op_type_i)
                OP_IMEM_WR: begin cmd_valid = 1'b1; is_wr = 1'b1; we_sel = 3'b001; region_base = NPU_IMEM_START; end
                OP_WMEM_WR: begin cmd_valid = 1'b1; is_wr = 1'b1; we_sel = 3'b010; region_base = NPU_WMEM_START; end
                OP_BMEM_WR: begin cmd_valid = 1'b1; is_wr = 1'b1; we_sel = 3'b100; region_base = NPU_BMEM_START; end
                OP_OMEM_RD: begin cmd_valid = 1'b1; is_rd = 1'b1; region_base = NPU_OMEM_START; end
                OP_OS, OP_MV: cmd_valid = 1'b1;
                default: cmd_valid = 1'b0;
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign running = (state_q == OS_RUN) || (state_q == MV_RUN);
    // Commands only take effect when idle; anything arriving while busy is dropped and flagged
    assign take    = cmd_valid && !busy;
    assign new_err = (cmd_valid && busy) || (core_done_i && !running);

    // Next-state and registered-output computation for the sequencer FSM and datapath
    always_comb begin
        state_d     = state_q;
        mem_we_d    = 3'b000;
        omem_re_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        wr_cnt_d    = wr_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (take && op_type_i == OP_OS) begin
                    state_d = OS_START;
                end else if (take && op_type_i == OP_MV) begin
                    state_d = MV_START;
                end
            end
            OS_START: state_d = OS_RUN;
            MV_START: state_d = MV_RUN;
            OS_RUN:   if (core_done_i) state_d = DONE;
            MV_RUN:   if (core_done_i) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (take && (is_wr || is_rd)) begin
            mem_addr_d = LADDR_WIDTH'(addr_i - region_base);
        end
        if (take && is_wr) begin
            mem_we_d    = we_sel;
            mem_wdata_d = wdata_i;
        end
        if (take && is_rd) begin
            omem_re_d = 1'b1;
        end

        // A fresh OS run restarts the write count; a write never coincides with that entry
        if (state_q == IDLE && state_d == OS_START) begin
            wr_cnt_d = 16'h0000;
        end else if (take && is_wr && wr_cnt_q != 16'hFFFF) begin
            wr_cnt_d = wr_cnt_q + 16'h0001;
        end

        // A new error wins over a simultaneous clear
        if (new_err) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mem_we_q    <= 3'b000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            omem_re_q   <= 1'b0;
            err_q       <= 1'b0;
            wr_cnt_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            omem_re_q   <= omem_re_d;
            err_q       <= err_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign omem_re_o   = omem_re_q;
    assign os_start_o  = (state_q == OS_START);
    assign mv_start_o  = (state_q == MV_START);
    assign busy_o      = busy;
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign wr_cnt_o    = wr_cnt_q;

endmodule

// File: tb/tb_npu_cmd_sequencer.sv
// tb/tb_npu_cmd_sequencer.sv - self-checking scoreboard bench for npu_cmd_sequencer
module tb_npu_cmd_sequencer;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int LW = 12;
    localparam logic [31:0] IMEM = 32'h1000_0000;
    localparam logic [31:0] WMEM = 32'h1001_0000;
    localparam logic [31:0] BMEM = 32'h1002_0000;
    localparam logic [31:0] OMEM = 32'h1003_0000;

    logic          clk;
    logic          rst_n;
    logic          cen;
    logic [3:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          core_done;
    logic          err_clr;
    logic [2:0]    mem_we;
    logic [LW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          omem_re;
    logic          os_start;
    logic          mv_start;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   wr_cnt;

    typedef struct packed {
        logic [2:0]    we;
        logic          re;
        logic [LW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;
    int   checks   = 0;
    int   failures = 0;

    npu_cmd_sequencer #(
        .DWidth(DW), .ADDR_WIDTH(AW), .LADDR_WIDTH(LW),
        .NPU_IMEM_START(IMEM), .NPU_WMEM_START(WMEM),
        .NPU_BMEM_START(BMEM), .NPU_OMEM_START(OMEM)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .cen_i(cen), .op_type_i(op),
        .addr_i(addr), .wdata_i(wdata), .core_done_i(core_done), .err_clr_i(err_clr),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .omem_re_o(omem_re), .os_start_o(os_start), .mv_start_o(mv_start),
        .busy_o(busy), .done_o(done), .err_o(err), .wr_cnt_o(wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void push_exp(input logic [3:0] o, input logic [31:0] a, input logic [7:0] d);
        exp_t        e;
        logic [31:0] diff;
        e = '0;
        case (o)
            4'b1000: begin e.we = 3'b001; diff = a - IMEM; end
            4'b1001: begin e.we = 3'b010; diff = a - WMEM; end
            4'b1010: begin e.we = 3'b100; diff = a - BMEM; end
            default: begin e.re = 1'b1;   diff = a - OMEM; end
        endcase
        e.addr = diff[LW-1:0];
        e.data = d;
        sb_q.push_back(e);
    endfunction

    // Scoreboard monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && (mem_we != 3'b000 || omem_re)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_strobe", {28'd0, mem_we, omem_re}, 32'd0);
            end else begin
                e_mon = sb_q.pop_front();
                check("sb_we", {29'd0, mem_we}, {29'd0, e_mon.we});
                check("sb_re", {31'd0, omem_re}, {31'd0, e_mon.re});
                check("sb_addr", {20'd0, mem_addr}, {20'd0, e_mon.addr});
                if (e_mon.we != 3'b000) check("sb_wdata", {24'd0, mem_wdata}, {24'd0, e_mon.data});
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] o, input logic [31:0] a, input logic [7:0] d, input bit expect_out);
        cen   = 1'b1;
        op    = o;
        addr  = a;
        wdata = d;
        if (expect_out) push_exp(o, a, d);
        tick();
        cen = 1'b0;
        op  = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b0; op = 4'b0000; addr = '0; wdata = '0;
        core_done = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        check("rst_we", {29'd0, mem_we}, 32'd0);
        check("rst_addr", {20'd0, mem_addr}, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_flags", {25'd0, omem_re, os_start, mv_start, busy, done, err, 1'b0}, 32'd0);
        check("rst_wr_cnt", {16'd0, wr_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // WMEM write at start+5
        cmd(4'b1001, WMEM + 32'd5, 8'hA5, 1'b1);
        check("wmem_we", {29'd0, mem_we}, 32'd2);
        check("wmem_addr", {20'd0, mem_addr}, 32'd5);
        check("wmem_wdata", {24'd0, mem_wdata}, 32'hA5);
        check("wmem_wr_cnt", {16'd0, wr_cnt}, 32'd1);
        tick();
        check("wmem_we_one_cycle", {29'd0, mem_we}, 32'd0);

        // Back-to-back writes to the other regions, including the top local address
        cmd(4'b1000, IMEM + 32'h10, 8'h3C, 1'b1);
        cmd(4'b1010, BMEM + 32'hFFF, 8'h77, 1'b1);
        cmd(4'b1011, OMEM + 32'd3, 8'h00, 1'b1);
        check("omem_re", {31'd0, omem_re}, 32'd1);
        check("omem_addr", {20'd0, mem_addr}, 32'd3);
        check("wr_cnt_3", {16'd0, wr_cnt}, 32'd3);

        // No-op code, and a write code without chip enable
        cen = 1'b1; op = 4'b0101; tick();
        cen = 1'b0; op = 4'b1000; tick();
        op = 4'b0000;
        check("noop_err", {31'd0, err}, 32'd0);
        check("noop_wr_cnt", {16'd0, wr_cnt}, 32'd3);

        // Stray core_done in IDLE, clear racing a new error, then plain clear
        core_done = 1'b1; tick(); core_done = 1'b0;
        check("idle_done_err", {31'd0, err}, 32'd1);
        err_clr = 1'b1; core_done = 1'b1; tick(); core_done = 1'b0;
        check("clr_vs_new_err", {31'd0, err}, 32'd1);
        tick(); err_clr = 1'b0;
        check("err_cleared", {31'd0, err}, 32'd0);

        // OS run with rejected commands while busy
        cmd(4'b1111, 32'd0, 8'h00, 1'b0);
        check("os_start_pulse", {31'd0, os_start}, 32'd1);
        check("os_busy", {31'd0, busy}, 32'd1);
        check("os_wr_cnt_clr", {16'd0, wr_cnt}, 32'd0);
        tick();
        check("os_start_once", {31'd0, os_start}, 32'd0);
        cmd(4'b1000, IMEM + 32'd1, 8'h11, 1'b0);
        check("busy_wr_err", {31'd0, err}, 32'd1);
        check("busy_wr_cnt", {16'd0, wr_cnt}, 32'd0);
        cmd(4'b1011, OMEM + 32'd3, 8'h00, 1'b0);
        check("busy_rd_re", {31'd0, omem_re}, 32'd0);
        check("busy_rd_err", {31'd0, err}, 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("busy_err_clr", {31'd0, err}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("os_run_busy", {30'd0, busy, done}, 32'd2);
            tick();
        end
        core_done = 1'b1; tick(); core_done = 1'b0;
        check("os_done_pulse", {31'd0, done}, 32'd1);
        check("os_done_busy", {31'd0, busy}, 32'd1);
        cmd(4'b1111, 32'd0, 8'h00, 1'b0);
        check("done_start_rej", {29'd0, busy, done, os_start}, 32'd0);
        check("done_start_err", {31'd0, err}, 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // MV run interrupted by reset
        cmd(4'b0001, 32'd0, 8'h00, 1'b0);
        check("mv_start_pulse", {30'd0, mv_start, busy}, 32'd3);
        tick();
        check("mv_run", {30'd0, mv_start, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async_busy", {30'd0, busy, done}, 32'd0);
        tick();
        check("rst_no_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        core_done = 1'b1; tick(); core_done = 1'b0;
        check("post_rst_done_err", {31'd0, err}, 32'd1);
        check("post_rst_done_done", {31'd0, done}, 32'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        cmd(4'b0001, 32'd0, 8'h00, 1'b0);
        check("mv_after_rst", {31'd0, mv_start}, 32'd1);
        tick();
        core_done = 1'b1; tick(); core_done = 1'b0;
        check("mv_done_pulse", {31'd0, done}, 32'd1);
        tick();
        check("mv_idle", {30'd0, busy, done}, 32'd0);

        // Write counter saturation and clear on OS start
        cen = 1'b1; op = 4'b1000;
        for (int i = 0; i < 70000; i++) begin
            addr  = IMEM + (i & 32'hFFF);
            wdata = i[7:0];
            push_exp(4'b1000, addr, wdata);
            tick();
        end
        cen = 1'b0; op = 4'b0000;
        check("wr_cnt_sat", {16'd0, wr_cnt}, 32'hFFFF);
        cmd(4'b1111, 32'd0, 8'h00, 1'b0);
        check("wr_cnt_os_clr", {16'd0, wr_cnt}, 32'd0);
        tick();
        core_done = 1'b1; tick(); core_done = 1'b0;
        repeat (3) tick();
        check("final_err", {31'd0, err}, 32'd0);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
